// File: rtl/score_pkg.sv
// Shared constants and types for the score display slice.
package score_pkg;

    localparam int NUM_DIGITS    = 4;
    localparam int GLYPH_W       = 8;
    localparam int GLYPH_H       = 16;
    localparam int HILITE_FRAMES = 32;
    localparam int HILITE_TOGGLE = 4;

    typedef logic [3:0] bcd_t;

    localparam bcd_t GLYPH_DASH = 4'hA;

    // Anything above 9 is not a decimal digit and is shown as a dash.
    function automatic bcd_t glyph_of(input bcd_t d);
        return (d > 4'd9) ? GLYPH_DASH : d;
    endfunction

endpackage

// File: rtl/score_digit_font.sv
// Registered 11x16x8 glyph ROM (digits 0-9 plus dash), built from seven-segment strokes.
module score_digit_font
    import score_pkg::*;
(
    input  logic       clk,
    input  bcd_t       glyph,
    input  logic [3:0] row,
    output logic [7:0] row_bits
);

    // Segment mask {g,f,e,d,c,b,a}; column 0 of the glyph is bit 7 of a row.
    function automatic logic [6:0] seg_map(input bcd_t g);
        case (g)
            4'd0:       return 7'h3F;
            4'd1:       return 7'h06;
            4'd2:       return 7'h5B;
            4'd3:       return 7'h4F;
            4'd4:       return 7'h66;
            4'd5:       return 7'h6D;
            4'd6:       return 7'h7D;
            4'd7:       return 7'h07;
            4'd8:       return 7'h7F;
            4'd9:       return 7'h6F;
            GLYPH_DASH: return 7'h40;
            default:    return 7'h00;
        endcase
    endfunction

    logic [6:0] seg;
    logic [7:0] row_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        row_next = 8'h00;
        seg      = seg_map(glyph);
        if (row == 4'd2)
            row_next = seg[0] ? 8'h7E : 8'h00;
        else if (row >= 4'd3 && row <= 4'd7)
            row_next = (seg[5] ? 8'h40 : 8'h00) | (seg[1] ? 8'h02 : 8'h00);
        else if (row == 4'd8)
            row_next = seg[6] ? 8'h7E : 8'h00;
        else if (row >= 4'd9 && row <= 4'd13)
            row_next = (seg[4] ? 8'h40 : 8'h00) | (seg[2] ? 8'h02 : 8'h00);
        else if (row == 4'd14)
            row_next = seg[3] ? 8'h7E : 8'h00;
    end

    // NOTE: ROM/datapath registers carry no reset; the qualifying valid bits downstream are reset instead.
    always_ff @(posedge clk) begin
        row_bits <= row_next;
    end

endmodule

// File: rtl/score_display.sv
// Four-digit score box renderer with frame-synchronous digit latch and 2-clock pixel pipeline.
// Optional build macro SCORE_BLINK_EN adds a 32-frame colour-swap highlight on value change.
module score_display
    import score_pkg::*;
#(
    parameter int         TOP_LEFT_X = 16,
    parameter int         TOP_LEFT_Y = 8,
    parameter int         SCALE      = 2,
    parameter int         DIGIT_GAP  = 4,
    parameter logic [7:0] FG_COLOR   = 8'hFF,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        digitsValid,
    input  logic [3:0]  num_of_thousands,
    input  logic [3:0]  num_of_hundreds,
    input  logic [3:0]  num_of_tens,
    input  logic [3:0]  num_of_units,
    output logic        drawingRequest,
    output logic [7:0]  RGBout
);

    localparam int DW     = GLYPH_W * SCALE;
    localparam int DH     = GLYPH_H * SCALE;
    localparam int STRIDE = DW + DIGIT_GAP;
    localparam int BOX_W  = NUM_DIGITS * DW + (NUM_DIGITS - 1) * DIGIT_GAP;

    localparam logic [10:0] BOX_X0 = 11'(TOP_LEFT_X);
    localparam logic [10:0] BOX_X1 = 11'(TOP_LEFT_X + BOX_W);
    localparam logic [10:0] BOX_Y0 = 11'(TOP_LEFT_Y);
    localparam logic [10:0] BOX_Y1 = 11'(TOP_LEFT_Y + DH);

    bcd_t [NUM_DIGITS-1:0] digits_in, shadow, disp, next_disp;

    assign digits_in = {num_of_thousands, num_of_hundreds, num_of_tens, num_of_units};
    assign next_disp = digitsValid ? digits_in : shadow;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (digitsValid)  shadow <= digits_in;
            if (startOfFrame) disp   <= next_disp;
        end
    end

    logic swap;

`ifdef SCORE_BLINK_EN
    localparam int HLW = $clog2(HILITE_FRAMES);
    logic           hl_active;
    logic [HLW-1:0] hl_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            hl_active <= 1'b0;
            hl_frame  <= '0;
        end else if (startOfFrame) begin
            if (next_disp != disp) begin
                hl_active <= 1'b1;
                hl_frame  <= '0;
            end else if (hl_active) begin
                if (hl_frame == HLW'(HILITE_FRAMES - 1)) hl_active <= 1'b0;
                else                                     hl_frame  <= hl_frame + 1'b1;
            end
        end
    end

    // Even toggle windows (frames 0-3, 8-11, ...) are the swapped ones.
    assign swap = hl_active && !hl_frame[$clog2(HILITE_TOGGLE)];
`else
    assign swap = 1'b0;
`endif

    // Leading-zero blanking walks down from the thousands; units are never blank.
    logic [NUM_DIGITS-1:0] blank;
    logic                  lead;

    always_comb begin
        blank = '0;
        lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            lead     = lead && (disp[k] == 4'd0);
            blank[k] = lead;
        end
    end

    // Stage 1: box hit, slot decode and glyph coordinates via constant thresholds (no divider).
    logic [10:0] dx, dy, sx;
    logic        in_box, in_digit;
    logic [1:0]  slot;
    logic [2:0]  col;
    logic [3:0]  row;

    always_comb begin
        in_digit = 1'b0;
        slot     = '0;
        sx       = '0;
        col      = '0;
        row      = '0;
        dx       = pixelX - BOX_X0;
        dy       = pixelY - BOX_Y0;
        in_box   = (pixelX >= BOX_X0) && (pixelX < BOX_X1) &&
                   (pixelY >= BOX_Y0) && (pixelY < BOX_Y1);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (dx >= 11'(k * STRIDE) && dx < 11'(k * STRIDE + DW)) begin
                in_digit = 1'b1;
                slot     = 2'(NUM_DIGITS - 1 - k);
                sx       = dx - 11'(k * STRIDE);
            end
        end
        for (int c = 1; c < GLYPH_W; c++)
            if (sx >= 11'(c * SCALE)) col = 3'(c);
        for (int r = 1; r < GLYPH_H; r++)
            if (dy >= 11'(r * SCALE)) row = 4'(r);
    end

    logic       s1_hit, s1_fg_en, s2_hit, s2_fg_en;
    bcd_t       s1_glyph;
    logic [3:0] s1_row;
    logic [2:0] s1_col, s2_col;
    logic [7:0] font_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_hit   <= 1'b0;
            s1_fg_en <= 1'b0;
            s2_hit   <= 1'b0;
            s2_fg_en <= 1'b0;
        end else begin
            s1_hit   <= in_box;
            s1_fg_en <= in_box && in_digit && !blank[slot];
            s2_hit   <= s1_hit;
            s2_fg_en <= s1_fg_en;
        end
    end

    always_ff @(posedge clk) begin
        s1_glyph <= glyph_of(disp[slot]);
        s1_row   <= row;
        s1_col   <= col;
        s2_col   <= s1_col;
    end

    // Stage 2: glyph row lookup registered inside the font ROM.
    score_digit_font u_font (
        .clk      (clk),
        .glyph    (s1_glyph),
        .row      (s1_row),
        .row_bits (font_row)
    );

    logic glyph_on;

    always_comb begin
        glyph_on       = s2_fg_en && font_row[3'(GLYPH_W - 1) - s2_col];
        drawingRequest = s2_hit;
        RGBout         = 8'h00;
        if (s2_hit) RGBout = (glyph_on ^ swap) ? FG_COLOR : BG_COLOR;
    end

endmodule
